// File: rtl/noc_pkg.sv
// Shared NoC packet definitions for the PE packetizer/depacketizer pair:
// field positions, node addresses, packet struct and PE address lookup.
package noc_pkg;

  localparam int PWIDTH    = 47;
  localparam int PAYLOAD_W = 40;
  localparam int TYPE_BIT  = 46;
  localparam int DEST_MSB  = 45;
  localparam int DEST_LSB  = 43;
  localparam int SRC_MSB   = 42;
  localparam int SRC_LSB   = 40;

  localparam logic [2:0] ADDER_ADDR = 3'd4;

  typedef struct packed {
    logic                 is_ifm;
    logic [2:0]           dest;
    logic [2:0]           src;
    logic [PAYLOAD_W-1:0] payload;
  } noc_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IFM  = 2'd1,
    ST_FILT = 2'd2
  } depkt_state_e;

  function automatic logic [2:0] pe_addr(input int index);
    case (index)
      0:       pe_addr = 3'd3;
      1:       pe_addr = 3'd1;
      2:       pe_addr = 3'd0;
      default: pe_addr = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/ifm_serializer.sv
// Holds an ifmap payload and streams it out one DWIDTH element per
// handshake, LSB element first, flagging the final element.
module ifm_serializer
  import noc_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int IFM_BYTES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DWIDTH-1:0]    o_data,
  output logic                 o_last,
  output logic                 o_done
);

  localparam int IDX_W = (IFM_BYTES > 1) ? $clog2(IFM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IFM_BYTES - 1);

  logic [PAYLOAD_W-1:0] r_payload;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_active;
  logic                 w_last;
  logic                 w_fire;

  assign w_last  = r_active && (r_idx == LAST_IDX);
  assign w_fire  = r_active && i_ready;
  assign o_done  = w_fire && w_last;
  assign o_valid = r_active;
  assign o_last  = w_last;
  assign o_data  = r_payload[DWIDTH*int'(r_idx) +: DWIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_payload <= '0;
      r_idx     <= '0;
      r_active  <= 1'b0;
    end else if (i_load) begin
      r_payload <= i_payload;
      r_idx     <= '0;
      r_active  <= 1'b1;
    end else if (w_fire) begin
      if (w_last) begin
        r_idx    <= '0;
        r_active <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_depacketizer.sv
// Splits NoC packets for one PE into an ifmap byte stream and filter frames.
// Define PE_DEPKT_ADDR_CHECK_EN to drop misaddressed packets and count them.
module pe_depacketizer
  import noc_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int PWIDTH    = 47,
  parameter int PE_INDEX  = 0,
  parameter int IFM_BYTES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PWIDTH-1:0]     in_packet,
  output logic                  ifm_valid,
  input  logic                  ifm_ready,
  output logic [DWIDTH-1:0]     ifm_data,
  output logic                  ifm_last,
  output logic                  filt_valid,
  input  logic                  filt_ready,
  output logic [3*DWIDTH-1:0]   filt_data,
  output logic [2:0]            filt_src,
  output logic [7:0]            drop_count
);

  if (PWIDTH != noc_pkg::PWIDTH) begin : g_err_pwidth
    $error("pe_depacketizer: PWIDTH must be 47");
  end
  if (PE_INDEX < 0 || PE_INDEX > 2) begin : g_err_index
    $error("pe_depacketizer: PE_INDEX must be 0, 1 or 2");
  end
  if (IFM_BYTES < 1 || IFM_BYTES * DWIDTH > PAYLOAD_W || 3 * DWIDTH > PAYLOAD_W) begin : g_err_bytes
    $error("pe_depacketizer: ifmap/filter fields do not fit the payload");
  end

  depkt_state_e          r_state;
  depkt_state_e          w_state_nxt;
  noc_pkt_t              w_pkt;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_take_ifm;
  logic                  w_take_filt;
  logic                  w_ifm_done;
  logic [3*DWIDTH-1:0]   r_filt_data;
  logic [2:0]            r_filt_src;

  assign w_pkt       = in_packet;
  assign w_accept    = in_valid && in_ready;
  assign w_take_ifm  = w_accept && !w_drop && w_pkt.is_ifm;
  assign w_take_filt = w_accept && !w_drop && !w_pkt.is_ifm;

`ifdef PE_DEPKT_ADDR_CHECK_EN
  localparam logic [2:0] LOCAL_ADDR = pe_addr(PE_INDEX);
  logic [7:0] r_drop_count;

  assign w_drop = w_accept && ((w_pkt.dest != LOCAL_ADDR) || (w_pkt.dest == ADDER_ADDR));
  assign drop_count = r_drop_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop && r_drop_count != 8'hFF) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end
`else
  logic w_unused_dest;

  assign w_unused_dest = ^w_pkt.dest;
  assign w_drop        = 1'b0;
  assign drop_count    = '0;
`endif

  ifm_serializer #(
    .DWIDTH    (DWIDTH),
    .IFM_BYTES (IFM_BYTES)
  ) u_ifm_serializer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_take_ifm),
    .i_payload (w_pkt.payload),
    .i_ready   (ifm_ready),
    .o_valid   (ifm_valid),
    .o_data    (ifm_data),
    .o_last    (ifm_last),
    .o_done    (w_ifm_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_filt_data <= '0;
      r_filt_src  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_filt) begin
        r_filt_data <= w_pkt.payload[3*DWIDTH-1:0];
        r_filt_src  <= w_pkt.src;
      end
    end
  end

  // in_ready is held low during reset so no packet is offered an ack that rst overrides
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    filt_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = !rst;
        if (w_take_ifm) begin
          w_state_nxt = ST_IFM;
        end else if (w_take_filt) begin
          w_state_nxt = ST_FILT;
        end
      end
      ST_IFM: begin
        if (w_ifm_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILT: begin
        filt_valid = 1'b1;
        if (filt_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign filt_data = r_filt_data;
  assign filt_src  = r_filt_src;

endmodule

// File: tb/tb_pe_depacketizer.sv
// Scoreboard bench for pe_depacketizer: expected ifmap elements and filter
// frames are queued when a packet is offered and popped on each output handshake.
module tb_pe_depacketizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [46:0] in_packet;
  logic        ifm_valid;
  logic        ifm_ready;
  logic [7:0]  ifm_data;
  logic        ifm_last;
  logic        filt_valid;
  logic        filt_ready;
  logic [23:0] filt_data;
  logic [2:0]  filt_src;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  ifm_q[$];
  logic [26:0] filt_q[$];

  pe_depacketizer #(
    .DWIDTH    (8),
    .PWIDTH    (47),
    .PE_INDEX  (0),
    .IFM_BYTES (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_packet  (in_packet),
    .ifm_valid  (ifm_valid),
    .ifm_ready  (ifm_ready),
    .ifm_data   (ifm_data),
    .ifm_last   (ifm_last),
    .filt_valid (filt_valid),
    .filt_ready (filt_ready),
    .filt_data  (filt_data),
    .filt_src   (filt_src),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: handshakes seen at the negedge fire on the next posedge
  logic        ifm_stall_q  = 1'b0;
  logic [8:0]  ifm_prev_q   = '0;
  logic        filt_stall_q = 1'b0;
  logic [26:0] filt_prev_q  = '0;

  always @(negedge clk) begin
    if (rst) begin
      ifm_stall_q  = 1'b0;
      filt_stall_q = 1'b0;
    end else begin
      if (ifm_valid && ifm_stall_q) chk("ifm_hold", {ifm_last, ifm_data}, ifm_prev_q);
      if (filt_valid && filt_stall_q) chk("filt_hold", {filt_src, filt_data}, filt_prev_q);
      if (ifm_valid && ifm_ready) begin
        if (ifm_q.size() == 0) chk("ifm_extra", 1, 0);
        else chk("ifm_elem", {ifm_last, ifm_data}, ifm_q.pop_front());
      end
      if (filt_valid && filt_ready) begin
        if (filt_q.size() == 0) chk("filt_extra", 1, 0);
        else chk("filt_frame", {filt_src, filt_data}, filt_q.pop_front());
      end
      ifm_stall_q  = ifm_valid && !ifm_ready;
      ifm_prev_q   = {ifm_last, ifm_data};
      filt_stall_q = filt_valid && !filt_ready;
      filt_prev_q  = {filt_src, filt_data};
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [46:0] pkt, output int waited);
    logic [46:0] p;
    p = pkt;
    in_packet = p;
    in_valid  = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) chk("accept_timeout", 0, 1);
    if (p[46]) begin
      for (int k = 0; k < 5; k++) ifm_q.push_back({(k == 4), p[8*k +: 8]});
    end else begin
      filt_q.push_back({p[42:40], p[23:0]});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_packet  = '0;
    ifm_ready  = 1'b0;
    filt_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ifm_valid", ifm_valid, 0);
    chk("rst_filt_valid", filt_valid, 0);
    chk("rst_ifm_last", ifm_last, 0);
    chk("rst_ifm_data", ifm_data, 0);
    chk("rst_filt_data", filt_data, 0);
    chk("rst_filt_src", filt_src, 0);
    chk("rst_drop", drop_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic ifmap packet at full ready
    ifm_ready = 1'b1;
    send({1'b1, 3'b011, 3'b100, 40'h0504030201}, w);
    chk("t1_accept_wait", w, 0);
    wait_idle(n);
    chk("t1_busy_cycles", n, 5);
    chk("t1_q_empty", ifm_q.size(), 0);

    // Filter frame held under backpressure
    send({1'b0, 3'b011, 3'b000, 16'h0, 24'h0A0B0C}, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_fvalid", filt_valid, 1);
      chk("t2_fdata", filt_data, 24'h0A0B0C);
      chk("t2_fsrc", filt_src, 0);
      chk("t2_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 filt_ready = 1'b1;
    wait_idle(n);
    chk("t2_release", n, 1);
    chk("t2_q_empty", filt_q.size(), 0);

    // Filter at full ready with fill bits set above the frame
    send({1'b0, 3'b011, 3'b101, 16'hFFFF, 24'h112233}, w);
    wait_idle(n);
    chk("t2b_busy_cycles", n, 1);
    chk("t2b_q_empty", filt_q.size(), 0);

    // Random ifm_ready stalls
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk);
          #1 ifm_ready = 1'($urandom_range(0, 1));
        end
        ifm_ready = 1'b1;
      end
      begin
        int wb;
        int nb;
        send({1'b1, 3'b011, 3'b010, 40'hA55AC33C81}, wb);
        wait_idle(nb);
      end
    join
    chk("t3_q_empty", ifm_q.size(), 0);

    // Reset after two elements delivered
    ifm_ready = 1'b1;
    send({1'b1, 3'b011, 3'b001, 40'h5544332211}, w);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    ifm_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_ifm_valid", ifm_valid, 0);
    chk("t4_drop", drop_count, 0);
    chk("t4_ifm_data", ifm_data, 0);
    chk("t4_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send({1'b1, 3'b011, 3'b001, 40'h0A09080706}, w);
    wait_idle(n);
    chk("t4_q_empty", ifm_q.size(), 0);

    // Filter offered while ifmap still streaming
    filt_ready = 1'b1;
    send({1'b1, 3'b011, 3'b110, 40'h1F1E1D1C1B}, w);
    send({1'b0, 3'b011, 3'b011, 16'h0, 24'hC0FFEE}, w);
    chk("t5_wait", w, 5);
    @(negedge clk);
    chk("t5_filt_valid", filt_valid, 1);
    @(posedge clk);
    #1;
    wait_idle(n);
    chk("t5_q_empty", ifm_q.size() + filt_q.size(), 0);

`ifdef PE_DEPKT_ADDR_CHECK_EN
    // Misaddressed packets are swallowed one per cycle
    in_packet = {1'b1, 3'b001, 3'b000, 40'h0102030405};
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_no_valid", ifm_valid | filt_valid, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_drop3", drop_count, 3);
    chk("t6_ifm_valid", ifm_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("t6_drop_sat", drop_count, 255);
    @(posedge clk);
    #1;
`else
    // Without address checking every dest is processed
    send({1'b1, 3'b001, 3'b000, 40'h0102030405}, w);
    wait_idle(n);
    chk("t6_processed", ifm_q.size(), 0);
    chk("t6_drop_zero", drop_count, 0);
`endif

    chk("end_ifm_q", ifm_q.size(), 0);
    chk("end_filt_q", filt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
